fcs_append: RTL and testbench



---
 rtl/fcs_append_pkg.sv | 24 ++
 rtl/fcs_append_crc32_dibit_step.sv | 23 ++
 rtl/fcs_append.sv | 165 ++++++++++++++++
 tb/tb_fcs_append.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcs_append_pkg.sv
// ============================================================================
// Module  : fcs_append_pkg
// Brief   : Shared CRC-32 constants and FSM encoding for the RMII FCS appender.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fcs_append_pkg;

    localparam logic [31:0] c_crc_poly = 32'hEDB88320;
    localparam logic [31:0] c_crc_seed = 32'hFFFFFFFF;
    localparam logic [7:0]  c_min_body = 8'd240;
    localparam int          c_fcs_len  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAD  = 2'd2,
        ST_FCS  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fcs_append_crc32_dibit_step.sv
// ============================================================================
// Module  : crc32_dibit_step
// Brief   : Reflected CRC-32 advance by one dibit (bit 0 first, then bit 1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module crc32_dibit_step
    import fcs_append_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [1:0]  i_dibit,
    output logic [31:0] o_crc
);

    logic [31:0] w_crc_b0;

    assign w_crc_b0 = {1'b0, i_crc[31:1]} ^ ((i_crc[0] ^ i_dibit[0]) ? c_crc_poly : 32'h0);
    assign o_crc    = {1'b0, w_crc_b0[31:1]} ^ ((w_crc_b0[0] ^ i_dibit[1]) ? c_crc_poly : 32'h0);

endmodule

`default_nettype wire

// File: rtl/fcs_append.sv
// ============================================================================
// Module  : fcs_append
// Brief   : Forwards an RMII dibit frame body with one cycle latency and
//           appends the Ethernet FCS; optional short-frame zero padding is
//           enabled by defining FCS_APPEND_PAD_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fcs_append
    import fcs_append_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       busy,
    output logic       ovf
);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_crc, w_crc_nxt, w_crc_step;
    logic [1:0]  w_fold_dibit;
    logic [3:0]  r_fcs_idx, w_fcs_idx_nxt;
    logic        r_axiov, w_axiov_nxt;
    logic [1:0]  r_axiod, w_axiod_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_ovf, w_ovf_nxt;
    logic        w_start_fcs;
`ifdef FCS_APPEND_PAD_EN
    logic [7:0]  r_body_cnt, w_body_cnt_nxt;
`endif

    // Pad dibits (and the cycle that enters padding) fold zeros into the CRC.
    assign w_fold_dibit = (axiiv && (r_state == ST_IDLE || r_state == ST_DATA)) ? axiid : 2'b00;

    crc32_dibit_step u_crc_step (
        .i_crc   (r_crc),
        .i_dibit (w_fold_dibit),
        .o_crc   (w_crc_step)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_crc_nxt     = r_crc;
        w_fcs_idx_nxt = r_fcs_idx;
        w_axiov_nxt   = 1'b0;
        w_axiod_nxt   = 2'b00;
        w_busy_nxt    = 1'b0;
        w_ovf_nxt     = axiiv && (r_state == ST_PAD || r_state == ST_FCS);
        w_start_fcs   = 1'b0;
`ifdef FCS_APPEND_PAD_EN
        w_body_cnt_nxt = r_body_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (axiiv) begin
                    w_state_nxt = ST_DATA;
                    w_crc_nxt   = w_crc_step;
                    w_axiov_nxt = 1'b1;
                    w_axiod_nxt = axiid;
`ifdef FCS_APPEND_PAD_EN
                    w_body_cnt_nxt = 8'd1;
`endif
                end
            end
            ST_DATA: begin
                if (axiiv) begin
                    w_crc_nxt   = w_crc_step;
                    w_axiov_nxt = 1'b1;
                    w_axiod_nxt = axiid;
`ifdef FCS_APPEND_PAD_EN
                    if (r_body_cnt != c_min_body) w_body_cnt_nxt = r_body_cnt + 8'd1;
`endif
                end else
`ifdef FCS_APPEND_PAD_EN
                if (r_body_cnt < c_min_body) begin
                    w_state_nxt    = ST_PAD;
                    w_crc_nxt      = w_crc_step;
                    w_axiov_nxt    = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_body_cnt_nxt = r_body_cnt + 8'd1;
                end else
`endif
                begin
                    w_start_fcs = 1'b1;
                end
            end
`ifdef FCS_APPEND_PAD_EN
            ST_PAD: begin
                if (r_body_cnt == c_min_body) begin
                    w_start_fcs = 1'b1;
                end else begin
                    w_crc_nxt      = w_crc_step;
                    w_axiov_nxt    = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_body_cnt_nxt = r_body_cnt + 8'd1;
                end
            end
`endif
            ST_FCS: begin
                // The CRC register doubles as the FCS shifter, low dibit first.
                w_axiov_nxt = 1'b1;
                w_axiod_nxt = ~r_crc[1:0];
                w_crc_nxt   = {2'b11, r_crc[31:2]};
                if (r_fcs_idx == 4'(c_fcs_len - 1)) begin
                    w_state_nxt   = ST_IDLE;
                    w_crc_nxt     = c_crc_seed;
                    w_fcs_idx_nxt = 4'd0;
                end else begin
                    w_fcs_idx_nxt = r_fcs_idx + 4'd1;
                    w_busy_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_start_fcs) begin
            w_state_nxt   = ST_FCS;
            w_axiov_nxt   = 1'b1;
            w_axiod_nxt   = ~r_crc[1:0];
            w_crc_nxt     = {2'b11, r_crc[31:2]};
            w_fcs_idx_nxt = 4'd1;
            w_busy_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_crc      <= c_crc_seed;
            r_fcs_idx  <= 4'd0;
            r_axiov    <= 1'b0;
            r_axiod    <= 2'b00;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
`ifdef FCS_APPEND_PAD_EN
            r_body_cnt <= 8'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_crc      <= w_crc_nxt;
            r_fcs_idx  <= w_fcs_idx_nxt;
            r_axiov    <= w_axiov_nxt;
            r_axiod    <= w_axiod_nxt;
            r_busy     <= w_busy_nxt;
            r_ovf      <= w_ovf_nxt;
`ifdef FCS_APPEND_PAD_EN
            r_body_cnt <= w_body_cnt_nxt;
`endif
        end
    end

    assign axiov = r_axiov;
    assign axiod = r_axiod;
    assign busy  = r_busy;
    assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fcs_append.sv
// ============================================================================
// Module  : tb_fcs_append
// Brief   : Scoreboard bench for fcs_append (honours FCS_APPEND_PAD_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fcs_append;

    logic       clk = 1'b0;
    logic       rst;
    logic       axiiv;
    logic [1:0] axiid;
    logic       axiov;
    logic [1:0] axiod;
    logic       busy;
    logic       ovf;

    always #5 clk = ~clk;

    fcs_append dut (
        .clk   (clk),
        .rst   (rst),
        .axiiv (axiiv),
        .axiid (axiid),
        .axiov (axiov),
        .axiod (axiod),
        .busy  (busy),
        .ovf   (ovf)
    );

`ifdef FCS_APPEND_PAD_EN
    localparam bit c_pad = 1'b1;
`else
    localparam bit c_pad = 1'b0;
`endif
    localparam logic [31:0] c_poly    = 32'hEDB88320;
    localparam logic [31:0] c_seed    = 32'hFFFFFFFF;
    localparam logic [31:0] c_residue = 32'hDEBB20E3;

    typedef struct packed {
        logic [1:0] d;
        logic       busy;
        logic       last;
        logic       res;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] body_q[$];
    int         checks   = 0;
    int         errors   = 0;
    int         ovf_seen = 0;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] x;
        x = c;
        for (int b = 0; b < 2; b++) begin
            if (x[0] != d[b]) x = (x >> 1) ^ c_poly;
            else              x = x >> 1;
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) body_q.push_back(b[2*k +: 2]);
    endtask

    task automatic load_string(input string s);
        body_q.delete();
        for (int i = 0; i < s.len(); i++) push_byte(s[i]);
    endtask

    task automatic load_pattern(input int n, input int mul, input int add);
        body_q.delete();
        for (int i = 0; i < n; i++) push_byte(8'(i * mul + add));
    endtask

    // Expected wire image: body, zero pad up to 240 dibits, then ~crc LSB first.
    task automatic push_expected(input bit use_hand, input logic [31:0] hand_fcs);
        logic [31:0] crc;
        logic [31:0] fcs;
        int          npad;
        crc  = c_seed;
        npad = (c_pad && body_q.size() < 240) ? 240 - body_q.size() : 0;
        foreach (body_q[i]) begin
            sb.push_back(exp_t'{d: body_q[i], busy: 1'b0, last: 1'b0, res: 1'b0});
            crc = crc_dibit(crc, body_q[i]);
        end
        for (int i = 0; i < npad; i++) begin
            sb.push_back(exp_t'{d: 2'b00, busy: 1'b1, last: 1'b0, res: 1'b0});
            crc = crc_dibit(crc, 2'b00);
        end
        fcs = use_hand ? hand_fcs : ~crc;
        for (int k = 0; k < 16; k++)
            sb.push_back(exp_t'{d: fcs[2*k +: 2], busy: (k != 15), last: (k == 15), res: 1'b1});
    endtask

    task automatic send_frame(input bit ovf_burst, input bit use_hand, input logic [31:0] hand_fcs);
        int npad;
        npad = (c_pad && body_q.size() < 240) ? 240 - body_q.size() : 0;
        push_expected(use_hand, hand_fcs);
        foreach (body_q[i]) begin
            axiiv = 1'b1;
            axiid = body_q[i];
            tick();
            if (i == 0) begin
                checks++;
                if (axiov !== 1'b1 || axiod !== body_q[0]) begin
                    errors++;
                    $display("FAIL first_latency axiov=%b axiod=%b expected axiov=1 axiod=%b",
                             axiov, axiod, body_q[0]);
                end
            end
        end
        // Input held high while FCS dibits 3..5 are on the output is dropped.
        for (int i = 0; i < npad + 16; i++) begin
            if (ovf_burst && i >= npad + 4 && i <= npad + 6) begin
                axiiv = 1'b1;
                axiid = 2'(i + 1);
            end else begin
                axiiv = 1'b0;
                axiid = 2'b00;
            end
            tick();
        end
        axiiv = 1'b0;
        axiid = 2'b00;
    endtask

    task automatic send_reset_at(input int k);
        for (int i = 0; i < k; i++)
            sb.push_back(exp_t'{d: body_q[i], busy: 1'b0, last: (i == k - 1), res: 1'b0});
        for (int i = 0; i < k; i++) begin
            axiiv = 1'b1;
            axiid = body_q[i];
            tick();
        end
        axiid = body_q[k];
        rst   = 1'b1;
        tick();
        checks++;
        if (axiov !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid axiov=%b busy=%b expected 0 0", axiov, busy);
        end
        rst   = 1'b0;
        axiiv = 1'b0;
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d expected 0", sb.size());
            sb.delete();
        end
        repeat (3) tick();
    endtask

    task automatic monitor();
        logic [31:0] mcrc;
        bit          mid;
        exp_t        e;
        mcrc = c_seed;
        mid  = 1'b0;
        forever begin
            @(negedge clk);
            if (ovf === 1'b1) ovf_seen++;
            if (axiov === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output axiod=%b expected no output", axiod);
                end else begin
                    e = sb.pop_front();
                    if (axiod !== e.d || busy !== e.busy) begin
                        errors++;
                        $display("FAIL out_dibit axiod=%b busy=%b expected axiod=%b busy=%b",
                                 axiod, busy, e.d, e.busy);
                    end
                    mcrc = crc_dibit(mcrc, axiod);
                    if (e.last) begin
                        if (e.res) begin
                            checks++;
                            if (mcrc !== c_residue) begin
                                errors++;
                                $display("FAIL rx_residue got=%h expected=%h", mcrc, c_residue);
                            end
                        end
                        mcrc = c_seed;
                        mid  = 1'b0;
                    end else begin
                        mid = 1'b1;
                    end
                end
            end else if (mid) begin
                checks++;
                errors++;
                $display("FAIL output_gap axiov=0 expected 1");
                mid  = 1'b0;
                mcrc = c_seed;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time_limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovf_before;
        rst   = 1'b1;
        axiiv = 1'b0;
        axiid = 2'b00;
        fork
            monitor();
        join_none
        repeat (3) tick();
        checks++;
        if (axiov !== 1'b0 || axiod !== 2'b00 || busy !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state axiov=%b axiod=%b busy=%b ovf=%b expected 0 00 0 0",
                     axiov, axiod, busy, ovf);
        end
        rst = 1'b0;
        repeat (2) tick();

        // Known check value: CRC-32("123456789") = 0xCBF43926 when unpadded.
        load_string("123456789");
        send_frame(1'b0, !c_pad, 32'hCBF43926);
        drain();

        load_pattern(64, 37, 5);
        send_frame(1'b0, 1'b0, 32'h0);
        drain();

        // Second frame starts in the cycle FCS dibit 15 is on the output.
        load_string("back to back A");
        send_frame(1'b0, 1'b0, 32'h0);
        load_pattern(70, 11, 200);
        send_frame(1'b0, 1'b0, 32'h0);
        drain();

        ovf_before = ovf_seen;
        load_pattern(20, 3, 77);
        send_frame(1'b1, 1'b0, 32'h0);
        drain();
        checks++;
        if (ovf_seen - ovf_before != 3) begin
            errors++;
            $display("FAIL ovf_pulses got=%0d expected=3", ovf_seen - ovf_before);
        end

        load_pattern(30, 13, 1);
        send_reset_at(10);
        drain();
        load_string("after reset frame");
        send_frame(1'b0, 1'b0, 32'h0);
        drain();

        checks++;
        if (ovf_seen != 3) begin
            errors++;
            $display("FAIL ovf_total got=%0d expected=3", ovf_seen);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
